// File: rtl/bpred_btb.sv
// -----------------------------------------------------------------------------
// bpred_btb -- front-end branch predictor: bimodal counters, a direct-mapped
// branch target buffer and an optional return-address stack.
//
// A lookup presented in cycle N yields a registered prediction in cycle N+1.
// Resolved branches from execute train the counters and the BTB. Lookups read
// the arrays before any same-cycle update lands (read-before-write).
//
// Optional feature: define BPRED_RAS_EN to compile in a circular return-address
// stack of RAS_DEPTH entries. Without it, returns predict the BTB target.
//
// Ports
//   clk          in   1   clock, all state changes on its rising edge
//   rst          in   1   asynchronous, active-high reset
//   lookup_valid in   1   request a prediction for lookup_pc
//   lookup_pc    in  32   fetch address
//   pred_valid   out  1   prediction for last cycle's lookup is valid
//   pred_taken   out  1   predicted path is redirected
//   pred_target  out 32   predicted next fetch address
//   upd_valid    in   1   resolved control-flow writeback
//   upd_pc       in  32   resolved instruction address
//   upd_target   in  32   actual target
//   upd_taken    in   1   actual outcome
//   upd_kind     in   2   00 cond, 01 jump, 10 call, 11 return
//   flush        in   1   mispredict redirect from execute
// -----------------------------------------------------------------------------
module bpred_btb #(
  parameter int BHT_IDX_W = 8,
  parameter int BTB_IDX_W = 6,
  parameter int RAS_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lookup_valid,
  input  logic [31:0] lookup_pc,
  output logic        pred_valid,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic [31:0] upd_target,
  input  logic        upd_taken,
  input  logic [1:0]  upd_kind,
  input  logic        flush
);

  localparam int BHT_N = 1 << BHT_IDX_W;
  localparam int BTB_N = 1 << BTB_IDX_W;
  localparam int TAG_W = 30 - BTB_IDX_W;

  localparam logic [1:0] K_COND = 2'b00;
  localparam logic [1:0] K_JUMP = 2'b01;
  localparam logic [1:0] K_CALL = 2'b10;
  localparam logic [1:0] K_RET  = 2'b11;

  // 2-bit saturating counter steps
  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    return (c == 2'b11) ? c : c + 2'b01;
  endfunction

  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    return (c == 2'b00) ? c : c - 2'b01;
  endfunction

  // Prediction state
  logic [1:0]       r_bht      [BHT_N];
  logic             r_btb_v    [BTB_N];
  logic [TAG_W-1:0] r_btb_tag  [BTB_N];
  logic [31:0]      r_btb_tgt  [BTB_N];
  logic [1:0]       r_btb_kind [BTB_N];

  // Registered prediction outputs
  logic        r_vld_p1;
  logic        r_taken_p1;
  logic [31:0] r_target_p1;

  // Lookup-side decode
  logic [BHT_IDX_W-1:0] w_l_bht_idx;
  logic [BTB_IDX_W-1:0] w_l_btb_idx;
  logic [TAG_W-1:0]     w_l_tag;
  logic                 w_hit;
  logic [1:0]           w_kind;
  logic [31:0]          w_btb_tgt;
  logic [1:0]           w_ctr;
  logic [31:0]          w_pc4;
  logic                 w_taken;
  logic [31:0]          w_target;

  // Update-side decode
  logic [BHT_IDX_W-1:0] w_u_bht_idx;
  logic [BTB_IDX_W-1:0] w_u_btb_idx;
  logic [TAG_W-1:0]     w_u_tag;

  // Address bits below the word boundary never take part in prediction
  logic w_unused;
  assign w_unused = ^{lookup_pc[1:0], upd_pc[1:0]};

  assign w_l_bht_idx = lookup_pc[BHT_IDX_W+1:2];
  assign w_l_btb_idx = lookup_pc[BTB_IDX_W+1:2];
  assign w_l_tag     = lookup_pc[31:BTB_IDX_W+2];
  assign w_u_bht_idx = upd_pc[BHT_IDX_W+1:2];
  assign w_u_btb_idx = upd_pc[BTB_IDX_W+1:2];
  assign w_u_tag     = upd_pc[31:BTB_IDX_W+2];

  assign w_hit     = r_btb_v[w_l_btb_idx] && (r_btb_tag[w_l_btb_idx] == w_l_tag);
  assign w_kind    = r_btb_kind[w_l_btb_idx];
  assign w_btb_tgt = r_btb_tgt[w_l_btb_idx];
  assign w_ctr     = r_bht[w_l_bht_idx];
  assign w_pc4     = lookup_pc + 32'd4;

`ifdef BPRED_RAS_EN
  localparam int RAS_PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int RAS_CNT_W = $clog2(RAS_DEPTH + 1);

  function automatic logic [RAS_PTR_W-1:0] ptr_inc(input logic [RAS_PTR_W-1:0] p);
    return (p == RAS_PTR_W'(RAS_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [RAS_PTR_W-1:0] ptr_dec(input logic [RAS_PTR_W-1:0] p);
    return (p == '0) ? RAS_PTR_W'(RAS_DEPTH - 1) : p - 1'b1;
  endfunction

  // r_ras_ptr is the next free slot; the top of stack sits just below it.
  // When full, the next free slot is also the oldest entry, so a push there
  // naturally overwrites the oldest return address.
  logic [31:0]          r_ras [RAS_DEPTH];
  logic [RAS_PTR_W-1:0] r_ras_ptr;
  logic [RAS_CNT_W-1:0] r_ras_cnt;
  logic [RAS_PTR_W-1:0] w_ras_top;
  logic                 w_ras_nonempty;
  logic                 w_push;
  logic                 w_pop;

  assign w_ras_top      = ptr_dec(r_ras_ptr);
  assign w_ras_nonempty = (r_ras_cnt != '0);
  assign w_push = lookup_valid && !flush && w_hit && (w_kind == K_CALL);
  assign w_pop  = lookup_valid && !flush && w_hit && (w_kind == K_RET) && w_ras_nonempty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ras_ptr <= '0;
      r_ras_cnt <= '0;
    end else if (flush) begin
      r_ras_cnt <= '0;
    end else if (w_push) begin
      r_ras_ptr <= ptr_inc(r_ras_ptr);
      if (r_ras_cnt != RAS_CNT_W'(RAS_DEPTH))
        r_ras_cnt <= r_ras_cnt + 1'b1;
    end else if (w_pop) begin
      r_ras_ptr <= w_ras_top;
      r_ras_cnt <= r_ras_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !rst)
      r_ras[r_ras_ptr] <= w_pc4;
  end
`else
  logic [31:0] w_unused_ras;
  assign w_unused_ras = 32'(RAS_DEPTH);
`endif

  // Prediction select; not-taken always falls through to pc+4
  always_comb begin
    w_taken  = 1'b0;
    w_target = w_pc4;
    if (w_hit) begin
      case (w_kind)
        K_COND: begin
          if (w_ctr[1]) begin
            w_taken  = 1'b1;
            w_target = w_btb_tgt;
          end
        end
        K_JUMP, K_CALL: begin
          w_taken  = 1'b1;
          w_target = w_btb_tgt;
        end
        K_RET: begin
          w_taken  = 1'b1;
          w_target = w_btb_tgt;
`ifdef BPRED_RAS_EN
          if (w_ras_nonempty)
            w_target = r_ras[w_ras_top];
`endif
        end
        default: begin
          w_taken  = 1'b0;
          w_target = w_pc4;
        end
      endcase
    end
  end

  // ---- stage p0 -> p1: register the prediction ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p1    <= 1'b0;
      r_taken_p1  <= 1'b0;
      r_target_p1 <= '0;
    end else begin
      r_vld_p1    <= lookup_valid && !flush;
      r_taken_p1  <= lookup_valid && w_taken;
      r_target_p1 <= w_target;
    end
  end

  assign pred_valid  = r_vld_p1;
  assign pred_taken  = r_taken_p1;
  assign pred_target = r_target_p1;

  // Training: counters and BTB valid bits carry reset state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_N; i++) r_bht[i] <= 2'b01;
      for (int i = 0; i < BTB_N; i++) r_btb_v[i] <= 1'b0;
    end else if (upd_valid) begin
      if (upd_kind == K_COND)
        r_bht[w_u_bht_idx] <= upd_taken ? ctr_inc(r_bht[w_u_bht_idx])
                                        : ctr_dec(r_bht[w_u_bht_idx]);
      if (upd_taken)
        r_btb_v[w_u_btb_idx] <= 1'b1;
    end
  end

  // BTB payload is only meaningful behind a valid bit, so it needs no reset
  always_ff @(posedge clk) begin
    if (upd_valid && upd_taken && !rst) begin
      r_btb_tag[w_u_btb_idx]  <= w_u_tag;
      r_btb_tgt[w_u_btb_idx]  <= upd_target;
      r_btb_kind[w_u_btb_idx] <= upd_kind;
    end
  end

endmodule

// File: tb/tb_bpred_btb.sv
// Scoreboard bench for bpred_btb: stimulus pushes the expected prediction into
// a queue, a negedge monitor pops and compares each cycle's DUT output.
module tb_bpred_btb;

  localparam int BHT_IDX_W = 8;
  localparam int BTB_IDX_W = 6;
  localparam int RAS_DEPTH = 8;
  localparam int BHT_N     = 1 << BHT_IDX_W;
  localparam int BTB_N     = 1 << BTB_IDX_W;

  logic        clk;
  logic        rst;
  logic        lookup_valid;
  logic [31:0] lookup_pc;
  logic        pred_valid;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [31:0] upd_target;
  logic        upd_taken;
  logic [1:0]  upd_kind;
  logic        flush;

  bpred_btb #(.BHT_IDX_W(BHT_IDX_W), .BTB_IDX_W(BTB_IDX_W), .RAS_DEPTH(RAS_DEPTH)) dut (
    .clk(clk), .rst(rst),
    .lookup_valid(lookup_valid), .lookup_pc(lookup_pc),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_target(pred_target),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target),
    .upd_taken(upd_taken), .upd_kind(upd_kind), .flush(flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic        t;
    logic [31:0] tg;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: counters as small integers, BTB as owner pc + target + kind,
  // return stack as a bounded queue of return addresses.
  int          m_ctr  [BHT_N];
  bit          m_v    [BTB_N];
  logic [31:0] m_pc   [BTB_N];
  logic [31:0] m_tgt  [BTB_N];
  logic [1:0]  m_kind [BTB_N];
  logic [31:0] m_ras  [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < BHT_N; i++) m_ctr[i] = 1;
    for (int i = 0; i < BTB_N; i++) m_v[i] = 0;
    m_ras.delete();
  endfunction

  // One clock of stimulus. Prediction uses model state before this cycle's update.
  task automatic cycle(input bit lv, input logic [31:0] lpc,
                       input bit uv, input logic [31:0] upc, input logic [31:0] utgt,
                       input bit utk, input logic [1:0] uk, input bit fl);
    exp_t e;
    int   bi, ci;
    lookup_valid = lv; lookup_pc = lpc;
    upd_valid = uv; upd_pc = upc; upd_target = utgt; upd_taken = utk; upd_kind = uk;
    flush = fl;
    e.v = lv && !fl && !rst; e.t = 1'b0; e.tg = lpc + 32'd4;
    if (!rst) begin
      if (lv) begin
        bi = int'((lpc >> 2) % BTB_N);
        ci = int'((lpc >> 2) % BHT_N);
        if (m_v[bi] && ((m_pc[bi] >> (BTB_IDX_W + 2)) == (lpc >> (BTB_IDX_W + 2)))) begin
          case (m_kind[bi])
            2'd0: if (m_ctr[ci] >= 2) begin e.t = 1'b1; e.tg = m_tgt[bi]; end
            2'd1: begin e.t = 1'b1; e.tg = m_tgt[bi]; end
            2'd2: begin
              e.t = 1'b1; e.tg = m_tgt[bi];
`ifdef BPRED_RAS_EN
              if (!fl) begin
                m_ras.push_back(lpc + 32'd4);
                if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
              end
`endif
            end
            default: begin
              e.t = 1'b1; e.tg = m_tgt[bi];
`ifdef BPRED_RAS_EN
              if (m_ras.size() > 0) begin
                e.tg = m_ras[$];
                if (!fl) void'(m_ras.pop_back());
              end
`endif
            end
          endcase
        end
      end
      if (fl) m_ras.delete();
      if (uv) begin
        ci = int'((upc >> 2) % BHT_N);
        bi = int'((upc >> 2) % BTB_N);
        if (uk == 2'd0) m_ctr[ci] = utk ? ((m_ctr[ci] < 3) ? m_ctr[ci] + 1 : 3)
                                        : ((m_ctr[ci] > 0) ? m_ctr[ci] - 1 : 0);
        if (utk) begin
          m_v[bi] = 1; m_pc[bi] = upc; m_tgt[bi] = utgt; m_kind[bi] = uk;
        end
      end
    end
    @(posedge clk);
    exp_q.push_back(e);
    #1;
  endtask

  task automatic look(input logic [31:0] pc);
    cycle(1, pc, 0, 32'h0, 32'h0, 0, 2'd0, 0);
  endtask

  task automatic train(input logic [31:0] pc, input logic [31:0] tgt, input bit tk, input logic [1:0] k);
    cycle(0, 32'h0, 1, pc, tgt, tk, k, 0);
  endtask

  task automatic idle();
    cycle(0, 32'h0, 0, 32'h0, 32'h0, 0, 2'd0, 0);
  endtask

  // Monitor: one expectation per clocked output cycle
  exp_t me;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      me = exp_q.pop_front();
      chk("pred_valid", {31'h0, pred_valid}, {31'h0, me.v});
      if (me.v) begin
        chk("pred_taken", {31'h0, pred_taken}, {31'h0, me.t});
        chk("pred_target", pred_target, me.tg);
      end
    end else if (pred_valid) begin
      chk("unexpected_pred_valid", {31'h0, pred_valid}, 32'h0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] rand_pc();
    logic [31:0] p;
    p = 32'h0001_0000 + (32'($urandom_range(0, 3)) << 8) + (32'($urandom_range(0, 15)) << 2);
    return p;
  endfunction

  initial begin
    rst = 1'b0; lookup_valid = 0; lookup_pc = '0; upd_valid = 0; upd_pc = '0;
    upd_target = '0; upd_taken = 0; upd_kind = '0; flush = 0;
    model_reset();
    #2 rst = 1'b1;
    #1;
    chk("reset_pred_valid", {31'h0, pred_valid}, 32'h0);
    chk("reset_pred_taken", {31'h0, pred_taken}, 32'h0);
    chk("reset_pred_target", pred_target, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    idle();
    look(32'h100);                               // miss -> 0x104

    train(32'h200, 32'h180, 1, 2'd0);
    train(32'h200, 32'h180, 1, 2'd0);
    look(32'h200);                               // taken -> 0x180
    repeat (3) train(32'h200, 32'h180, 0, 2'd0);
    look(32'h200);                               // not taken -> 0x204

    cycle(1, 32'h300, 1, 32'h300, 32'h340, 1, 2'd0, 0);  // read-before-write miss
    look(32'h300);                               // now a hit

    train(32'h400, 32'h800, 1, 2'd2);
    train(32'h810, 32'h999, 1, 2'd3);
    look(32'h400);
    look(32'h810);

    for (int k = 0; k < 9; k++) train(32'h2020 + 32'(4 * k), 32'h3000 + 32'(16 * k), 1, 2'd2);
    for (int k = 0; k < 9; k++) look(32'h2020 + 32'(4 * k));
    for (int k = 0; k < 9; k++) look(32'h810);

    cycle(1, 32'h400, 0, 32'h0, 32'h0, 0, 2'd0, 1);       // flush kills prediction
    look(32'h810);
    look(32'hFFFF_FFFC);                         // wraps to 0
    train(32'h500, 32'h0, 0, 2'd1);              // not-taken jump leaves BTB alone
    look(32'h500);

    for (int n = 0; n < 1500; n++) begin
      cycle($urandom_range(0, 3) != 0, rand_pc(),
            $urandom_range(0, 1) == 1, rand_pc(), $urandom() & 32'hFFFF_FFFC,
            $urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)),
            $urandom_range(0, 19) == 0);
    end

    // Mid-stream asynchronous reset
    look(32'h400);
    @(negedge clk); #1;
    chk("pre_rst_pred_valid", {31'h0, pred_valid}, 32'h1);
    rst = 1'b1;
    #1;
    chk("async_rst_pred_valid", {31'h0, pred_valid}, 32'h0);
    chk("async_rst_pred_taken", {31'h0, pred_taken}, 32'h0);
    chk("async_rst_pred_target", pred_target, 32'h0);
    exp_q.delete();
    model_reset();
    cycle(1, 32'h400, 1, 32'h600, 32'h700, 1, 2'd1, 0);   // ignored under reset
    cycle(1, 32'h200, 1, 32'h600, 32'h700, 1, 2'd1, 0);
    rst = 1'b0;
    look(32'h400);
    look(32'h200);
    look(32'h600);
    look(32'h810);
    repeat (3) idle();
    @(negedge clk); #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
